ftdi_mass_tx_gen: RTL



---
 rtl/ftdi_mass_pkg.sv | 30 +++
 rtl/ftdi_mass_len_rx.sv | 45 ++++
 rtl/ftdi_mass_tx_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ftdi_mass_pkg.sv
// Shared definitions for the FTDI mass-transfer TX pattern generator.
package ftdi_mass_pkg;

  // Number of RX bytes that make up the little-endian length field.
  localparam int unsigned LEN_BYTES = 4;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    StRecv = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2
  } state_e;

  // Byte enables for a word given the bytes still owed in the burst.
  function automatic logic [3:0] keep_from_rem(input logic [31:0] rem);
    logic [3:0] keep;
    if (rem >= 32'd4) begin
      keep = 4'b1111;
    end else begin
      unique case (rem[1:0])
        2'd3:    keep = 4'b0111;
        2'd2:    keep = 4'b0011;
        2'd1:    keep = 4'b0001;
        default: keep = 4'b0000;
      endcase
    end
    return keep;
  endfunction

endpackage

// File: rtl/ftdi_mass_len_rx.sv
// Collects LEN_BYTES RX bytes into a little-endian length word.
module ftdi_mass_len_rx
  import ftdi_mass_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_en,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  output logic [31:0] len,
  output logic        len_valid
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      len_q, len_d;
  logic             accept;

  assign accept = rx_en & rx_tvalid;

  // Shift each accepted byte into its slot; index wraps after the last byte.
  always_comb begin
    idx_d = idx_q;
    len_d = len_q;
    if (accept) begin
      len_d[8*idx_q +: 8] = rx_tdata;
      idx_d = (idx_q == IDX_W'(LEN_BYTES - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Byte index and assembled length register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      len_q <= '0;
    end else begin
      idx_q <= idx_d;
      len_q <= len_d;
    end
  end

  // Pulses in the cycle the final byte is accepted; len_q is complete one cycle later.
  assign len_valid = accept && (idx_q == IDX_W'(LEN_BYTES - 1));
  assign len       = len_q;

endmodule

// File: rtl/ftdi_mass_tx_gen.sv
// Throughput engine: receives a 32-bit byte count, then streams that many
// incrementing pattern bytes as 32-bit AXI-stream words.
module ftdi_mass_tx_gen
  import ftdi_mass_pkg::*;
#(
  parameter logic [7:0]  PAT_INIT = 8'h00,
  parameter logic [31:0] MAX_LEN  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_tready,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [31:0] tx_tdata,
  output logic [3:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        busy,
  output logic        burst_done
);

  state_e      state_q, state_d;
  logic        rx_tready_q, rx_tready_d;
  logic [31:0] len;
  logic        len_valid;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  pat_q, pat_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] clamp_diff;
  logic [31:0] rem_clamp;
  logic [31:0] rem_step;
  logic [31:0] rem_after;
  logic [7:0]  pat_after;
  logic        tx_hs;

  // Pattern bytes pat, pat+1, ... in enabled lanes; masked lanes are zero.
  function automatic logic [31:0] make_word(input logic [7:0] pat, input logic [3:0] keep);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = keep[i] ? pat + 8'(i) : 8'h00;
    end
    return w;
  endfunction

  ftdi_mass_len_rx u_len_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_en     (rx_tready_q),
    .rx_tvalid (rx_tvalid),
    .rx_tdata  (rx_tdata),
    .len       (len),
    .len_valid (len_valid)
  );

  // Borrow out means len > MAX_LEN; otherwise MAX_LEN - diff recovers len.
  assign clamp_diff = {1'b0, MAX_LEN} - {1'b0, len};
  assign rem_clamp  = clamp_diff[32] ? MAX_LEN : MAX_LEN - clamp_diff[31:0];

  assign tx_hs     = tvalid_q & tx_tready;
  assign rem_step  = (rem_q >= 32'd4) ? 32'd4 : rem_q;
  assign rem_after = rem_q - rem_step;
  assign pat_after = pat_q + 8'd4;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRecv;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRecv: if (len_valid) state_d = StLoad;
      StLoad: state_d = (rem_clamp != 32'd0) ? StSend : StRecv;
      StSend: if (tx_hs && (rem_after == 32'd0)) state_d = StRecv;
      default: state_d = StRecv;
    endcase
  end

  // Next values for the registered outputs and burst counters.
  always_comb begin
    logic [3:0] keep;
    keep        = 4'b0000;
    rx_tready_d = (state_d == StRecv);
    rem_d       = rem_q;
    pat_d       = pat_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StLoad: begin
        rem_d = rem_clamp;
        pat_d = PAT_INIT;
        if (rem_clamp != 32'd0) begin
          keep     = keep_from_rem(rem_clamp);
          tvalid_d = 1'b1;
          tkeep_d  = keep;
          tdata_d  = make_word(PAT_INIT, keep);
          tlast_d  = (rem_clamp <= 32'd4);
          busy_d   = 1'b1;
        end
      end
      StSend: begin
        if (tx_hs) begin
          rem_d = rem_after;
          pat_d = pat_after;
          if (rem_after == 32'd0) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            keep     = keep_from_rem(rem_after);
            tvalid_d = 1'b1;
            tkeep_d  = keep;
            tdata_d  = make_word(pat_after, keep);
            tlast_d  = (rem_after <= 32'd4);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_tready_q <= 1'b0;
      rem_q       <= '0;
      pat_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_tready_q <= rx_tready_d;
      rem_q       <= rem_d;
      pat_q       <= pat_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rx_tready  = rx_tready_q;
  assign tx_tvalid  = tvalid_q;
  assign tx_tdata   = tdata_q;
  assign tx_tkeep   = tkeep_q;
  assign tx_tlast   = tlast_q;
  assign busy       = busy_q;
  assign burst_done = done_q;

endmodule
